// File: rtl/jpeg_unstuff.sv
// JPEG entropy-segment byte unstuffer: strips FF00 stuffing, fill bytes and RSTn markers, detects EOI
// and hands a one-cycle end-of-scan strobe to the bit buffer. JPEG_UNSTUFF_STATS_EN adds statistics counters.
module jpeg_unstuff
`ifdef JPEG_UNSTUFF_STATS_EN
  #(parameter int unsigned STAT_W = 16)
`endif
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              img_start_i,
  input  logic              inport_valid_i,
  input  logic [7:0]        inport_data_i,
  input  logic              inport_last_i,
  output logic              inport_ready_o,
  output logic              outport_valid_o,
  output logic [7:0]        outport_data_o,
  input  logic              outport_ready_i,
  output logic              outport_last_o,
  output logic              restart_o,
  output logic [2:0]        restart_idx_o,
`ifdef JPEG_UNSTUFF_STATS_EN
  output logic [STAT_W-1:0] stuff_cnt_o,
  output logic [STAT_W-1:0] rst_cnt_o,
  output logic [STAT_W-1:0] fill_cnt_o,
`endif
  output logic              error_o
);

  typedef enum logic [1:0] {ST_DATA, ST_SEEN_FF, ST_DONE} state_e;

  state_e     state_q;
  logic       out_v_q;
  logic [7:0] out_d_q;
  logic       last_pend_q;
  logic       last_q;
  logic       restart_q;
  logic [2:0] restart_idx_q;
  logic       error_q;

  logic slot_free;
  logic in_acc;
  logic in_ff;
  logic is_rst;
  logic is_eoi;

  assign slot_free      = !out_v_q || outport_ready_i;
  assign inport_ready_o = (state_q != ST_DONE) && !last_pend_q && slot_free;
  assign in_acc         = inport_valid_i && inport_ready_o;
  assign in_ff          = (inport_data_i == 8'hFF);
  assign is_rst         = (inport_data_i[7:3] == 5'b11010);
  assign is_eoi         = (state_q == ST_SEEN_FF) && (inport_data_i == 8'hD9);

`ifdef JPEG_UNSTUFF_STATS_EN
  logic [STAT_W-1:0] stuff_cnt_q, rst_cnt_q, fill_cnt_q;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni || img_start_i) begin
      stuff_cnt_q <= '0;
      rst_cnt_q   <= '0;
      fill_cnt_q  <= '0;
    end else if (in_acc && state_q == ST_SEEN_FF) begin
      if (inport_data_i == 8'h00) stuff_cnt_q <= sat_inc(stuff_cnt_q);
      if (in_ff)                  fill_cnt_q  <= sat_inc(fill_cnt_q);
      if (is_rst)                 rst_cnt_q   <= sat_inc(rst_cnt_q);
    end
  end

  assign stuff_cnt_o = stuff_cnt_q;
  assign rst_cnt_o   = rst_cnt_q;
  assign fill_cnt_o  = fill_cnt_q;
`endif

  // NOTE: reset is synchronous, so rst_ni is tested inside the clocked block and not in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || img_start_i) begin
      state_q       <= ST_DATA;
      out_v_q       <= 1'b0;
      out_d_q       <= 8'h00;
      last_pend_q   <= 1'b0;
      last_q        <= 1'b0;
      restart_q     <= 1'b0;
      restart_idx_q <= 3'd0;
      error_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let later statements override earlier defaults within one edge.
      restart_q <= 1'b0;
      last_q    <= 1'b0;
      if (out_v_q && outport_ready_i) out_v_q <= 1'b0;
      // The strobe waits for the slot to empty, so it never coincides with a data beat.
      if (last_pend_q && slot_free) begin
        last_q      <= 1'b1;
        last_pend_q <= 1'b0;
      end
      if (in_acc) begin
        unique case (state_q)
          ST_DATA: begin
            if (in_ff) begin
              state_q <= ST_SEEN_FF;
            end else begin
              out_v_q <= 1'b1;
              out_d_q <= inport_data_i;
            end
          end
          ST_SEEN_FF: begin
            state_q <= ST_DATA;
            if (inport_data_i == 8'h00) begin
              out_v_q <= 1'b1;
              out_d_q <= 8'hFF;
            end else if (in_ff) begin
              state_q <= ST_SEEN_FF;
            end else if (is_rst) begin
              restart_q     <= 1'b1;
              restart_idx_q <= inport_data_i[2:0];
            end else if (is_eoi) begin
              last_pend_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              error_q <= 1'b1;
            end
          end
          default: ;
        endcase
        // A truncated stream ends the scan; a dangling FF means the marker was cut off.
        if (inport_last_i && !is_eoi) begin
          last_pend_q <= 1'b1;
          state_q     <= ST_DONE;
          if (in_ff) error_q <= 1'b1;
        end
      end
    end
  end

  assign outport_valid_o = out_v_q;
  assign outport_data_o  = out_d_q;
  assign outport_last_o  = last_q;
  assign restart_o       = restart_q;
  assign restart_idx_o   = restart_idx_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_jpeg_unstuff.sv
// Self-checking bench for jpeg_unstuff: directed and random byte streams compared against a
// look-ahead parsing model of the marker rules; statistics checked when JPEG_UNSTUFF_STATS_EN is defined.
module tb_jpeg_unstuff;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst_ni, img_start_i;
  logic       inport_valid_i, inport_last_i, inport_ready_o;
  logic [7:0] inport_data_i;
  logic       outport_valid_o, outport_ready_i, outport_last_o;
  logic [7:0] outport_data_o;
  logic       restart_o, error_o;
  logic [2:0] restart_idx_o;
`ifdef JPEG_UNSTUFF_STATS_EN
  logic [15:0] stuff_cnt_o, rst_cnt_o, fill_cnt_o;
`endif

  always #5 clk = ~clk;

  jpeg_unstuff dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .img_start_i     (img_start_i),
    .inport_valid_i  (inport_valid_i),
    .inport_data_i   (inport_data_i),
    .inport_last_i   (inport_last_i),
    .inport_ready_o  (inport_ready_o),
    .outport_valid_o (outport_valid_o),
    .outport_data_o  (outport_data_o),
    .outport_ready_i (outport_ready_i),
    .outport_last_o  (outport_last_o),
    .restart_o       (restart_o),
    .restart_idx_o   (restart_idx_o),
`ifdef JPEG_UNSTUFF_STATS_EN
    .stuff_cnt_o     (stuff_cnt_o),
    .rst_cnt_o       (rst_cnt_o),
    .fill_cnt_o      (fill_cnt_o),
`endif
    .error_o         (error_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model results
  logic [7:0] exp_out[$];
  logic [2:0] exp_rst[$];
  bit         exp_err;
  int         exp_n, exp_stuff, exp_rstn, exp_fill;

  // Parse the stream with look-ahead over runs of FF rather than byte-by-byte state.
  task automatic model(input bq_t b, input bit lend);
    int i, j;
    bit done;
    logic [7:0] m;
    exp_out.delete(); exp_rst.delete();
    exp_err = 0; exp_stuff = 0; exp_rstn = 0; exp_fill = 0;
    exp_n = b.size(); done = 0; i = 0;
    while (i < b.size() && !done) begin
      if (b[i] != 8'hFF) begin
        exp_out.push_back(b[i]);
        i++;
      end else begin
        j = i;
        while (j < b.size() && b[j] == 8'hFF) j++;
        exp_fill += j - i - 1;
        if (j == b.size()) begin
          if (lend) exp_err = 1;
          i = j;
        end else begin
          m = b[j];
          if (m == 8'h00) begin
            exp_out.push_back(8'hFF); exp_stuff++;
          end else if (m >= 8'hD0 && m <= 8'hD7) begin
            exp_rst.push_back(m[2:0]); exp_rstn++;
          end else if (m == 8'hD9) begin
            done = 1; exp_n = j + 1;
          end else begin
            exp_err = 1;
          end
          i = j + 1;
        end
      end
    end
  endtask

  // Output monitor: captures beats, restarts and last strobes, and checks the hold rule.
  logic [7:0] got_q[$];
  logic [2:0] rst_q[$];
  int   last_cnt, data_at_last, stall_cnt;
  logic prev_stall = 1'b0;
  logic [7:0] prev_d = 8'h00;

  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_valid", outport_valid_o, 1);
      check("hold_data", outport_data_o, prev_d);
    end
    if (outport_valid_o && outport_ready_i) got_q.push_back(outport_data_o);
    if (outport_valid_o && !outport_ready_i) stall_cnt++;
    if (restart_o) rst_q.push_back(restart_idx_o);
    if (outport_last_o) begin
      last_cnt++;
      data_at_last = got_q.size();
      check("last_no_valid", outport_valid_o, 0);
    end
    prev_stall = rst_ni && !img_start_i && outport_valid_o && !outport_ready_i;
    prev_d     = outport_data_o;
  end

  // Sink ready: 0 always ready, 1 random, 2 stall first 5 valid cycles, 3 never ready
  int rdy_mode = 0;
  int stall_left = 0;

  initial begin
    outport_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: outport_ready_i = 1'b1;
        1: outport_ready_i = ($urandom_range(0, 3) != 0);
        2: if (stall_left > 0 && outport_valid_o) begin
             outport_ready_i = 1'b0;
             stall_left--;
           end else outport_ready_i = 1'b1;
        default: outport_ready_i = 1'b0;
      endcase
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_capture();
    got_q.delete(); rst_q.delete();
    last_cnt = 0; data_at_last = -1; stall_cnt = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, inport_ready_o, 1);
    check({tag, "_valid"}, outport_valid_o, 0);
    check({tag, "_data"}, outport_data_o, 0);
    check({tag, "_last"}, outport_last_o, 0);
    check({tag, "_restart"}, restart_o, 0);
    check({tag, "_ridx"}, restart_idx_o, 0);
    check({tag, "_error"}, error_o, 0);
`ifdef JPEG_UNSTUFF_STATS_EN
    check({tag, "_stuffcnt"}, stuff_cnt_o, 0);
    check({tag, "_rstcnt"}, rst_cnt_o, 0);
    check({tag, "_fillcnt"}, fill_cnt_o, 0);
`endif
  endtask

  task automatic pulse_img_start(input string tag);
    img_start_i = 1'b1;
    cyc(1);
    img_start_i = 1'b0;
    check_idle(tag);
  endtask

  task automatic send(input bq_t b, input int n, input bit last_flag);
    int budget;
    bit acc;
    for (int i = 0; i < n; i++) begin
      inport_valid_i = 1'b1;
      inport_data_i  = b[i];
      inport_last_i  = last_flag && (i == n - 1);
      budget = 0;
      acc = 0;
      while (!acc && budget < 200) begin
        @(negedge clk);
        acc = inport_ready_o;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    inport_valid_i = 1'b0;
    inport_last_i  = 1'b0;
  endtask

  task automatic run_case(input string name, input bq_t b, input bit lend, input int mode);
    int budget;
    model(b, lend);
    clear_capture();
    rdy_mode = mode;
    stall_left = (mode == 2) ? 5 : 0;
    send(b, exp_n, lend && (exp_n == b.size()));
    budget = 0;
    while (last_cnt == 0 && budget < 400) begin cyc(1); budget++; end
    cyc(3);
    check({name, "_last_cnt"}, last_cnt, 1);
    check({name, "_nout"}, got_q.size(), exp_out.size());
    for (int i = 0; i < got_q.size() && i < exp_out.size(); i++)
      check($sformatf("%s_out%0d", name, i), got_q[i], exp_out[i]);
    check({name, "_data_at_last"}, data_at_last, exp_out.size());
    check({name, "_nrst"}, rst_q.size(), exp_rst.size());
    for (int i = 0; i < rst_q.size() && i < exp_rst.size(); i++)
      check($sformatf("%s_rst%0d", name, i), rst_q[i], exp_rst[i]);
    check({name, "_ridx_held"}, restart_idx_o, (exp_rst.size() > 0) ? exp_rst[$] : 3'd0);
    check({name, "_error"}, error_o, exp_err);
    check({name, "_done_ready"}, inport_ready_o, 0);
    check({name, "_drained"}, outport_valid_o, 0);
    if (mode == 2) check({name, "_stall_cycles"}, stall_cnt, 5);
`ifdef JPEG_UNSTUFF_STATS_EN
    check({name, "_stuffcnt"}, stuff_cnt_o, exp_stuff);
    check({name, "_rstcnt"}, rst_cnt_o, exp_rstn);
    check({name, "_fillcnt"}, fill_cnt_o, exp_fill);
`endif
    rdy_mode = 0;
    pulse_img_start({name, "_clr"});
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 30) return 8'hFF;
    if (r < 45) return 8'h00;
    if (r < 55) return 8'hD0 + 8'($urandom_range(0, 7));
    if (r < 58) return 8'hC4;
    if (r < 60) return 8'hD9;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    bq_t s;
    bit  lend;
    rst_ni = 1'b0; img_start_i = 1'b0;
    inport_valid_i = 1'b0; inport_data_i = 8'h00; inport_last_i = 1'b0;
    cyc(2);
    check_idle("reset");
    rst_ni = 1'b1;
    cyc(1);

    s = '{8'h12, 8'h34, 8'hFF, 8'h00, 8'h56};          run_case("stuff", s, 1, 0);
    s = '{8'hAB, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hCD};   run_case("fill", s, 1, 0);
    s = '{8'h11, 8'hFF, 8'hD3, 8'h22};                 run_case("rstn", s, 1, 0);
    s = '{8'h7E, 8'hFF, 8'hD9};                        run_case("eoi_stall", s, 0, 2);
    s = '{8'h01, 8'hFF, 8'hC4, 8'h02};                 run_case("badmark", s, 1, 0);
    s = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};   run_case("stuff3", s, 1, 0);
    s = '{8'h55, 8'hFF};                               run_case("trail_ff", s, 1, 0);
    s = '{8'hD9, 8'hFF, 8'hD7, 8'hFF, 8'hD9, 8'h99};   run_case("eoi_mid", s, 0, 1);

    // img_start coinciding with a handshake discards the byte and clears SEEN_FF
    clear_capture();
    s = '{8'hFF};
    send(s, 1, 0);
    inport_valid_i = 1'b1; inport_data_i = 8'h42; img_start_i = 1'b1;
    cyc(1);
    inport_valid_i = 1'b0; img_start_i = 1'b0;
    cyc(2);
    check("imgstart_drop", got_q.size(), 0);
    s = '{8'h00};
    send(s, 1, 1);
    cyc(4);
    check("imgstart_state_n", got_q.size(), 1);
    if (got_q.size() > 0) check("imgstart_state_d", got_q[0], 8'h00);
    check("imgstart_last", last_cnt, 1);
    pulse_img_start("imgstart_clr");

    // Reset with a full slot and a pending last: nothing further appears
    clear_capture();
    rdy_mode = 3;
    s = '{8'h5A};
    send(s, 1, 1);
    cyc(2);
    check("midrst_held", outport_valid_o, 1);
    rst_ni = 1'b0;
    cyc(1);
    rst_ni = 1'b1;
    rdy_mode = 0;
    cyc(10);
    check("midrst_nout", got_q.size(), 0);
    check("midrst_nolast", last_cnt, 0);
    check_idle("midrst");

    for (int t = 0; t < 20; t++) begin
      s.delete();
      for (int k = 0; k < int'($urandom_range(8, 40)); k++) s.push_back(rand_byte());
      lend = $urandom_range(0, 1);
      if (!lend) begin s.push_back(8'hFF); s.push_back(8'hD9); end
      run_case($sformatf("rnd%0d", t), s, lend, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
